// File: rtl/programmer_boot_ctrl.sv
// UART programmer sequencer: packs received bytes into little-endian words and writes them
// to consecutive instruction-memory addresses while holding the core in reset.
module programmer_boot_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  output logic                  core_hold_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  output logic                  overflow_err_o
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   Capacity = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StFlush,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  req_q, req_d;
  logic                  ovf_q, ovf_d;

  logic        take;
  logic        complete;
  logic        at_cap;
  logic        granted;
  logic [31:0] full_word;

  // Zero the bytes of a partial word that were never received.
  function automatic logic [31:0] keep_bytes(input logic [31:0] word, input logic [1:0] nbytes);
    logic [31:0] mask;
    case (nbytes)
      2'd1:    mask = 32'h0000_00ff;
      2'd2:    mask = 32'h0000_ffff;
      2'd3:    mask = 32'h00ff_ffff;
      default: mask = 32'hffff_ffff;
    endcase
    return word & mask;
  endfunction

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q   <= '0;
      asm_q   <= '0;
      wdata_q <= '0;
      addr_q  <= BaseAddr;
      count_q <= '0;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    count_d = count_q;
    req_d   = req_q;
    ovf_d   = ovf_q;

    take      = rx_valid_i && (state_q inside {StCollect, StWrite, StFlush});
    complete  = take && (idx_q == 2'd3);
    full_word = {rx_data_i, asm_q[23:0]};
    at_cap    = (count_q == Capacity);
    granted   = req_q && mem_gnt_i;

    if (take && !complete) begin
      asm_d[{idx_q, 3'b000} +: 8] = rx_data_i;
      idx_d                       = idx_q + 2'd1;
    end
    // Completing byte while a write is outstanding is dropped; the index parks at 3.
    if (complete && req_q) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (enable_i) begin
          state_d = StCollect;
          idx_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          addr_d  = BaseAddr;
        end
      end
      StCollect: begin
        if (complete) begin
          idx_d = '0;
          if (at_cap) begin
            ovf_d = 1'b1;
          end else begin
            wdata_d = full_word;
            req_d   = 1'b1;
            state_d = StWrite;
          end
        end
        // A byte landing with the falling enable is already folded into idx_d/asm_d.
        if (!enable_i && (state_d == StCollect)) begin
          if (idx_d == 2'd0) begin
            state_d = StDone;
          end else if (at_cap) begin
            ovf_d   = 1'b1;
            state_d = StDone;
          end else begin
            wdata_d = keep_bytes(asm_d, idx_d);
            req_d   = 1'b1;
            idx_d   = '0;
            state_d = StFlush;
          end
        end
      end
      StWrite: begin
        if (granted) begin
          req_d   = 1'b0;
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          state_d = enable_i ? StCollect : StFlush;
        end
      end
      StFlush: begin
        if (granted) begin
          req_d   = 1'b0;
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          state_d = StDone;
        end else if (!req_q) begin
          // Entered straight from a write grant: decide whether anything is left to flush.
          if (complete) begin
            idx_d = '0;
            if (at_cap) begin
              ovf_d   = 1'b1;
              state_d = StDone;
            end else begin
              wdata_d = full_word;
              req_d   = 1'b1;
            end
          end else if (idx_d == 2'd0) begin
            state_d = StDone;
          end else if (at_cap) begin
            ovf_d   = 1'b1;
            state_d = StDone;
          end else begin
            wdata_d = keep_bytes(asm_d, idx_d);
            req_d   = 1'b1;
            idx_d   = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    mem_req_o      = req_q;
    mem_addr_o     = addr_q;
    mem_wdata_o    = wdata_q;
    core_hold_o    = (state_q != StIdle);
    busy_o         = (state_q != StIdle);
    done_o         = (state_q == StDone);
    word_count_o   = count_q;
    overflow_err_o = ovf_q;
  end

  req_stable_a: assert property (@(posedge clk_i) disable iff (reset_i)
    req_q && !mem_gnt_i |=> req_q && $stable(addr_q) && $stable(wdata_q));

  count_bound_a: assert property (@(posedge clk_i) disable iff (reset_i)
    count_q <= Capacity);

endmodule

// File: tb/tb_programmer_boot_ctrl.sv
// Self-checking bench for programmer_boot_ctrl: randomized byte sessions against a
// byte-list model of the expected memory writes.
module tb_programmer_boot_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        gnt = 1'b0;
  logic        gnt_s = 1'b1;

  logic        req, hold, busy, done, ovf;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [12:0] count;

  logic        req_s, hold_s, busy_s, done_s, ovf_s;
  logic [1:0]  addr_s;
  logic [31:0] wdata_s;
  logic [2:0]  count_s;

  int checks = 0;
  int errors = 0;
  int gnt_mode = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_addr_s[$];
  logic [31:0] wr_data_s[$];
  logic [7:0]  sent[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_ovf;

  programmer_boot_ctrl u_dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .enable_i       (enable),
    .rx_valid_i     (rx_valid),
    .rx_data_i      (rx_data),
    .mem_req_o      (req),
    .mem_addr_o     (addr),
    .mem_wdata_o    (wdata),
    .mem_gnt_i      (gnt),
    .core_hold_o    (hold),
    .busy_o         (busy),
    .done_o         (done),
    .word_count_o   (count),
    .overflow_err_o (ovf)
  );

  programmer_boot_ctrl #(
    .ADDR_WIDTH (2),
    .BASE_ADDR  (0)
  ) u_small (
    .clk_i          (clk),
    .reset_i        (reset),
    .enable_i       (enable),
    .rx_valid_i     (rx_valid),
    .rx_data_i      (rx_data),
    .mem_req_o      (req_s),
    .mem_addr_o     (addr_s),
    .mem_wdata_o    (wdata_s),
    .mem_gnt_i      (gnt_s),
    .core_hold_o    (hold_s),
    .busy_o         (busy_s),
    .done_o         (done_s),
    .word_count_o   (count_s),
    .overflow_err_o (ovf_s)
  );

  always #5 clk = ~clk;

  // Grant driver and write monitor: values set here are the ones seen at the next posedge.
  initial begin
    int zeros;
    zeros = 0;
    forever begin
      @(negedge clk);
      case (gnt_mode)
        0: gnt = 1'b1;
        1: gnt = 1'b0;
        default: begin
          gnt   = (zeros >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
          zeros = gnt ? 0 : zeros + 1;
        end
      endcase
      if (req && gnt) begin
        wr_addr.push_back(int'(addr));
        wr_data.push_back(wdata);
      end
      if (req_s && gnt_s) begin
        wr_addr_s.push_back(int'(addr_s));
        wr_data_s.push_back(wdata_s);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Expected writes: bytes grouped four at a time, first byte lowest, tail zero-padded,
  // truncated at capacity.
  task automatic model_session(input int cap);
    int          nwords;
    logic [31:0] w;
    nwords = (sent.size() + 3) / 4;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < nwords && i < cap; i++) begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * i + k < sent.size()) w[8*k +: 8] = sent[4*i + k];
      end
      exp_addr.push_back(i);
      exp_data.push_back(w);
    end
    exp_ovf = (nwords > cap);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    sent.push_back(b);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic start_session();
    sent.delete();
    wr_addr.delete();
    wr_data.delete();
    wr_addr_s.delete();
    wr_data_s.delete();
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_session(output int dones);
    enable = 1'b0;
    dones  = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req, hold, busy, done, ovf} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {req, hold, busy, done, ovf});
    end
    checks++;
    if (addr !== 12'd0 || wdata !== 32'd0 || count !== 13'd0) begin
      errors++;
      $display("FAIL reset_regs got addr=%0h data=%0h cnt=%0d want 0", addr, wdata, count);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hold !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b hold=%b want 0", busy, hold);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8];
    bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6f, 8'h00, 8'h00, 8'h00};
    gnt_mode = 0;
    start_session();
    checks++;
    if (busy !== 1'b1 || hold !== 1'b1) begin
      errors++;
      $display("FAIL start_latency got busy=%b hold=%b want 1", busy, hold);
    end
    for (int i = 0; i < 8; i++) send_byte(bytes[i], 2);
    checks++;
    if (count !== 13'd2) begin
      errors++;
      $display("FAIL basic_count got %0d want 2", count);
    end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || hold !== 1'b1) begin
      errors++;
      $display("FAIL basic_done got done=%b hold=%b want 1 1", done, hold);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || hold !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release got done=%b hold=%b busy=%b want 0", done, hold, busy);
    end
    model_session(4096);
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL basic_nwrites got %0d want %0d", wr_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL basic_write%0d got %0h@%0d want %0h@%0d", i, wr_data[i], wr_addr[i],
                   exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] word1;
    int          viol;
    int          dones;
    gnt_mode = 1;
    start_session();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
    word1 = {sent[3], sent[2], sent[1], sent[0]};
    viol  = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2 || i == 8 || i == 14) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        sent.push_back(rx_data);
      end else begin
        rx_valid = 1'b0;
      end
      @(negedge clk);
      if (req !== 1'b1 || addr !== 12'd0 || wdata !== word1) viol++;
    end
    rx_valid = 1'b0;
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL stall_stable got %0d unstable cycles want 0 (data %0h)", viol, word1);
    end
    gnt_mode = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (count !== 13'd1 || req !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got cnt=%0d req=%b want 1 0", count, req);
    end
    send_byte(8'($urandom), 3);
    end_session(dones);
    model_session(4096);
    checks++;
    if (count !== 13'd2 || ovf !== 1'b0 || dones != 1) begin
      errors++;
      $display("FAIL stall_end got cnt=%0d ovf=%b dones=%0d want 2 0 1", count, ovf, dones);
    end
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL stall_nwrites got %0d want %0d", wr_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL stall_write%0d got %0h@%0d want %0h@%0d", i, wr_data[i], wr_addr[i],
                   exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    gnt_mode = 0;
    start_session();
    send_byte(8'haa, 1);
    send_byte(8'hbb, 1);
    send_byte(8'hcc, 1);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (req !== 1'b1 || wdata !== 32'h00cc_bbaa || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_req got req=%b data=%0h done=%b want 1 00ccbbaa 0", req, wdata, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || count !== 13'd1) begin
      errors++;
      $display("FAIL flush_done got done=%b cnt=%0d want 1 1", done, count);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() != 1) begin
      errors++;
      $display("FAIL flush_nwrites got %0d want 1", wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 0 || wr_data[0] !== 32'h00cc_bbaa) begin
        errors++;
        $display("FAIL flush_write got %0h@%0d want 00ccbbaa@0", wr_data[0], wr_addr[0]);
      end
    end
  endtask

  task automatic test_overflow();
    int dones;
    gnt_mode = 1;
    start_session();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1);
    void'(sent.pop_back());
    checks++;
    if (ovf !== 1'b1 || req !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got ovf=%b req=%b want 1 1", ovf, req);
    end
    gnt_mode = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_addr.size() != 1 || count !== 13'd1) begin
      errors++;
      $display("FAIL ovf_first_only got writes=%0d cnt=%0d want 1 1", wr_addr.size(), count);
    end
    end_session(dones);
    model_session(4096);
    checks++;
    if (ovf !== 1'b1 || dones != 1) begin
      errors++;
      $display("FAIL ovf_sticky got ovf=%b dones=%0d want 1 1", ovf, dones);
    end
    checks++;
    if (wr_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL ovf_nwrites got %0d want %0d", wr_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL ovf_write%0d got %0h@%0d want %0h@%0d", i, wr_data[i], wr_addr[i],
                   exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_capacity();
    int dones;
    gnt_mode = 0;
    start_session();
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 2);
    end_session(dones);
    model_session(4);
    checks++;
    if (count_s !== 3'd4 || ovf_s !== exp_ovf) begin
      errors++;
      $display("FAIL cap_small got cnt=%0d ovf=%b want 4 %b", count_s, ovf_s, exp_ovf);
    end
    checks++;
    if (count !== 13'd5 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL cap_large got cnt=%0d ovf=%b want 5 0", count, ovf);
    end
    checks++;
    if (wr_addr_s.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL cap_nwrites got %0d want %0d", wr_addr_s.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        checks++;
        if (wr_addr_s[i] !== exp_addr[i] || wr_data_s[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL cap_write%0d got %0h@%0d want %0h@%0d", i, wr_data_s[i],
                   wr_addr_s[i], exp_data[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    gnt_mode = 1;
    start_session();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got req=%b want 1", req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({req, hold, busy, done, ovf} !== 5'b0 || addr !== 12'd0 || wdata !== 32'd0 ||
        count !== 13'd0) begin
      errors++;
      $display("FAIL midrst_async got flags=%b addr=%0h data=%0h cnt=%0d want 0",
               {req, hold, busy, done, ovf}, addr, wdata, count);
    end
    @(negedge clk);
    reset    = 1'b0;
    gnt_mode = 0;
    @(negedge clk);
    start_session();
    checks++;
    if (ovf !== 1'b0 || count !== 13'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart got ovf=%b cnt=%0d busy=%b want 0 0 1", ovf, count, busy);
    end
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 2);
    end_session(dones);
    model_session(4096);
    checks++;
    if (wr_addr.size() != 1 || dones != 1) begin
      errors++;
      $display("FAIL midrst_nwrites got %0d dones=%0d want 1 1", wr_addr.size(), dones);
    end else begin
      checks++;
      if (wr_addr[0] !== exp_addr[0] || wr_data[0] !== exp_data[0]) begin
        errors++;
        $display("FAIL midrst_write got %0h@%0d want %0h@%0d", wr_data[0], wr_addr[0],
                 exp_data[0], exp_addr[0]);
      end
    end
  endtask

  task automatic test_random();
    int dones;
    int n;
    for (int s = 0; s < 6; s++) begin
      gnt_mode = 2;
      start_session();
      n = $urandom_range(1, 30);
      for (int i = 0; i < n; i++) send_byte(8'($urandom), $urandom_range(2, 4));
      end_session(dones);
      model_session(4096);
      checks++;
      if (count !== 13'(exp_addr.size()) || ovf !== exp_ovf || dones != 1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_status got cnt=%0d ovf=%b dones=%0d busy=%b want %0d %b 1 0",
                 s, count, ovf, dones, busy, exp_addr.size(), exp_ovf);
      end
      checks++;
      if (wr_addr.size() != exp_addr.size()) begin
        errors++;
        $display("FAIL rand%0d_nwrites got %0d want %0d", s, wr_addr.size(), exp_addr.size());
      end else begin
        foreach (exp_addr[i]) begin
          checks++;
          if (wr_addr[i] !== exp_addr[i] || wr_data[i] !== exp_data[i]) begin
            errors++;
            $display("FAIL rand%0d_write%0d got %0h@%0d want %0h@%0d", s, i, wr_data[i],
                     wr_addr[i], exp_data[i], exp_addr[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    repeat (3) @(negedge clk);
    test_stall();
    test_flush();
    repeat (3) @(negedge clk);
    test_overflow();
    test_capacity();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
